// File: rtl/modport_fifo_pkg.sv
// -----------------------------------------------------------------------------
// modport_fifo_pkg
//   Shared sizing for the modport_fifo codebase slice.
//   WIDTH  : data word width (taken from the shared `WIDTH macro, default 8)
//   DEPTH  : number of FIFO entries (power of two, >= 4)
//   ADDR_W : pointer width, derived from DEPTH
//   data_t : one data word
// -----------------------------------------------------------------------------
`ifndef WIDTH
`define WIDTH 8
`endif

package modport_fifo_pkg;

    localparam int WIDTH  = `WIDTH;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = $clog2(DEPTH);

    typedef logic [WIDTH-1:0] data_t;

endpackage

// File: rtl/modport_fifo_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
//   DEPTH x WIDTH storage for modport_fifo. Synchronous write port, combinational
//   read address, registered read data. The array itself is never reset; only
//   the read-data register returns to zero on reset.
// Ports
//   clk      in   clock
//   rstn     in   asynchronous active-low reset (read-data register only)
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   re_i     in   read enable; loads rdata_o from raddr_i
//   raddr_i  in   read address
//   rdata_o  out  registered read data, holds when re_i is low
// -----------------------------------------------------------------------------
module fifo_mem #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // When the FIFO is full and a read and write hit the same slot in one
    // cycle, the read sees the old word, which is the one being dequeued.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/modport_fifo.sv
// -----------------------------------------------------------------------------
// modport_fifo
//   Single-clock synchronous FIFO between a write-side producer and a read-side
//   consumer. Data accepted on wr_enb is returned in order on rd_enb with one
//   cycle of read latency. Status flags decode combinationally from the count
//   register; overflow/underflow are registered one-cycle error pulses.
// Ports
//   clk        in   clock, all state updates on posedge
//   rstn       in   asynchronous active-low reset
//   wr_enb     in   write request
//   wr_data    in   write data, captured with wr_enb
//   rd_enb     in   read request
//   rd_data    out  registered read data
//   full       out  count == DEPTH
//   empty      out  count == 0
//   half       out  count >= DEPTH/2
//   overflow   out  pulse: previous-cycle write rejected because full
//   underflow  out  pulse: previous-cycle read rejected because empty
// -----------------------------------------------------------------------------
module modport_fifo
    import modport_fifo_pkg::*;
#(
    parameter int WIDTH = modport_fifo_pkg::WIDTH,
    parameter int DEPTH = modport_fifo_pkg::DEPTH
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr_enb,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_enb,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic             half,
    output logic             overflow,
    output logic             underflow
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              wr_acc, rd_acc;

    // Flags follow the count register directly, so they move in the same
    // cycle the count does.
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign half  = (count_q >= CNT_W'(DEPTH / 2));

    // A write while full is still accepted if a read frees a slot this cycle.
    assign wr_acc = wr_enb && (!full || rd_enb);
    assign rd_acc = rd_enb && !empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = wr_enb && full && !rd_enb;
        underflow_d = rd_enb && empty;

        // Pointers wrap naturally at ADDR_W bits.
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    fifo_mem #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .rstn    (rstn),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data),
        .re_i    (rd_acc),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

endmodule

// File: tb/tb_modport_fifo.sv
// -----------------------------------------------------------------------------
// tb_modport_fifo
//   Directed, self-checking bench for modport_fifo. A queue holds the words the
//   FIFO should contain; each read the bench expects to be accepted pops the
//   head and compares it against rd_data one cycle later. Flags and error
//   pulses are checked against the queue occupancy every cycle.
// -----------------------------------------------------------------------------
module tb_modport_fifo;
    import modport_fifo_pkg::*;

    logic        clk;
    logic        rstn;
    logic        wr_enb;
    data_t       wr_data;
    logic        rd_enb;
    data_t       rd_data;
    logic        full;
    logic        empty;
    logic        half;
    logic        overflow;
    logic        underflow;

    int          checks;
    int          errors;
    data_t       sb[$];
    data_t       last_rd;

    modport_fifo dut (
        .clk       (clk),
        .rstn      (rstn),
        .wr_enb    (wr_enb),
        .wr_data   (wr_data),
        .rd_enb    (rd_enb),
        .rd_data   (rd_data),
        .full      (full),
        .empty     (empty),
        .half      (half),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag);
        int n;
        n = sb.size();
        chk({tag, "/full"},  32'(full),  32'(n == 16));
        chk({tag, "/empty"}, 32'(empty), 32'(n == 0));
        chk({tag, "/half"},  32'(half),  32'(n >= 8));
    endtask

    // One clock of traffic. Called at posedge+1; returns at the next posedge+1
    // after checking every output.
    task automatic step(input logic w, input data_t d, input logic r, input string tag);
        int    n;
        logic  wacc, racc, exp_of, exp_uf;
        data_t exp_rd;
        n      = sb.size();
        wacc   = w && (n < 16 || r);
        racc   = r && (n > 0);
        exp_of = w && (n == 16) && !r;
        exp_uf = r && (n == 0);
        exp_rd = racc ? sb[0] : last_rd;

        wr_enb  = w;
        wr_data = d;
        rd_enb  = r;
        @(posedge clk);
        #1;
        wr_enb = 1'b0;
        rd_enb = 1'b0;

        if (racc) void'(sb.pop_front());
        if (wacc) sb.push_back(d);
        last_rd = exp_rd;

        chk({tag, "/rd_data"},   32'(rd_data),   32'(exp_rd));
        chk({tag, "/overflow"},  32'(overflow),  32'(exp_of));
        chk({tag, "/underflow"}, 32'(underflow), 32'(exp_uf));
        chk_flags(tag);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        last_rd = '0;
        rstn    = 1'b0;
        wr_enb  = 1'b0;
        wr_data = '0;
        rd_enb  = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset/rd_data",   32'(rd_data),   32'h0);
        chk("reset/overflow",  32'(overflow),  32'h0);
        chk("reset/underflow", 32'(underflow), 32'h0);
        chk_flags("reset");
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Fill 0x01..0x10, half after the 8th write, full after the 16th
        for (int i = 1; i <= 16; i++) step(1'b1, data_t'(i), 1'b0, "fill");

        // Overflow: rejected write of 0xAA, pulse lasts exactly one cycle
        step(1'b1, 8'hAA, 1'b0, "ovf");
        step(1'b0, 8'h00, 1'b0, "ovf_clear");

        // Drain: 0x01..0x10 in order, no 0xAA
        for (int i = 1; i <= 16; i++) step(1'b0, 8'h00, 1'b1, "drain");
        chk("drain/last", 32'(rd_data), 32'h10);

        // Underflow: rd_data holds, empty stays 1
        step(1'b0, 8'h00, 1'b1, "udf");
        step(1'b0, 8'h00, 1'b0, "udf_clear");

        // Read+write while empty: write accepted, read rejected, no write-through
        step(1'b1, 8'h5C, 1'b1, "rw_empty");
        step(1'b0, 8'h00, 1'b1, "rw_empty_drain");

        // Count 5, then 20 simultaneous ops; pointers wrap, data stays ordered
        for (int i = 0; i < 5; i++) step(1'b1, data_t'(8'h20 + i), 1'b0, "pre5");
        for (int i = 0; i < 20; i++) step(1'b1, data_t'(8'h40 + i), 1'b1, "rw5");
        chk("rw5/count5", 32'(sb.size()), 32'd5);

        // Top up to full, then read+write at full: no overflow, full stays
        for (int i = 0; i < 11; i++) step(1'b1, data_t'(8'h80 + i), 1'b0, "topup");
        for (int i = 0; i < 3; i++) step(1'b1, data_t'(8'hC0 + i), 1'b1, "rw_full");

        // Partially drain to count 9, then async reset between edges
        for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1, "to9");
        chk("pre_rst/count9", 32'(sb.size()), 32'd9);
        #2;
        rstn = 1'b0;
        #1;
        chk("async_rst/empty",   32'(empty),   32'h1);
        chk("async_rst/half",    32'(half),    32'h0);
        chk("async_rst/full",    32'(full),    32'h0);
        chk("async_rst/rd_data", 32'(rd_data), 32'h0);
        sb.delete();
        last_rd = '0;
        #2;
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // First read after reset underflows
        step(1'b0, 8'h00, 1'b1, "post_rst_udf");
        step(1'b1, 8'h77, 1'b0, "post_rst_wr");
        step(1'b0, 8'h00, 1'b1, "post_rst_rd");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
